// File: rtl/miniCPU_defs.sv
// Shared encodings for the miniCPU fetch path: opcodes, the reserved NOP word,
// and the sequencer state encoding.
package miniCPU_defs;

  localparam int ADDR_W_DEF  = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int INSTR_W_DEF = 12;

  localparam logic [3:0] OPCODE_CPU_FIRST = 4'b0000;
  localparam logic [3:0] OPCODE_CPU_LAST  = 4'b1001;
  localparam logic [3:0] OPCODE_NOP       = 4'b1010;
  localparam logic [3:0] OPCODE_JUMP      = 4'b1110;
  localparam logic [3:0] OPCODE_HALT      = 4'b1111;

  localparam logic [11:0] NOP_INSTR = 12'hA00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write, combinational read. Contents survive reset,
// so a program loaded once can be replayed after any number of resets.
module prog_mem #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch stage for miniCPU: owns the PC and a run/step/halt FSM, consumes JUMP
// and HALT locally, and feeds one registered instruction per cycle to the CPU.
//
// state     | meaning
// ST_IDLE   | not issuing; Step issues one word, Start enters RUN from PC=0
// ST_RUN    | issuing one word per clock until Stop or a HALT word
// ST_HALTED | parked after a HALT word; only Start leaves
module instr_sequencer
  import miniCPU_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Step,
  input  logic               Stop,
  input  logic               PWrEn,
  input  logic [ADDR_W-1:0]  PWrAddr,
  input  logic [INSTR_W-1:0] PWrData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic [ADDR_W-1:0]  PC,
  output logic               Running,
  output logic               Halted
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;

  logic               start_issue;
  logic               issue;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] fetch_word;
  logic [3:0]         fetch_op;
  logic               mem_wr_en;

  // Start from IDLE or HALTED ignores the current PC and fetches word 0.
  assign start_issue = Start && (state_q != ST_RUN);
  assign issue       = start_issue
                    || ((state_q == ST_IDLE) && Step)
                    || ((state_q == ST_RUN) && !Stop);
  assign fetch_addr  = start_issue ? '0 : pc_q;
  assign fetch_op    = fetch_word[INSTR_W-1 -: 4];

  // Writes would race a fetch of the same cycle, so any issue request blocks them.
  assign mem_wr_en = PWrEn && (state_q != ST_RUN) && !Start && !Step && !Reset;

  prog_mem #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_prog_mem (
    .clk     (Clock),
    .wr_en   (mem_wr_en),
    .wr_addr (PWrAddr),
    .wr_data (PWrData),
    .rd_addr (fetch_addr),
    .rd_data (fetch_word)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= INSTR_W'(NOP_INSTR);
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_RUN;
      ST_RUN:    if (Stop) state_d = ST_IDLE;
      ST_HALTED: if (Start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (issue && (fetch_op == OPCODE_HALT)) begin
      state_d = ST_HALTED;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = INSTR_W'(NOP_INSTR);
    valid_d = 1'b0;
    if (issue) begin
      case (fetch_op)
        OPCODE_JUMP: pc_d = fetch_word[ADDR_W-1:0];
        OPCODE_HALT: pc_d = fetch_addr + ADDR_W'(1);
        default: begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          pc_d    = fetch_addr + ADDR_W'(1);
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALTED);
  end

  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;
  assign Running    = running_q;
  assign Halted     = halted_q;

endmodule
